extend_pipe: RTL and testbench
==============================

Name: extend_pipe

Overview:
- Parametrised, pipelined successor to the combinational sign-extender.
- Takes an immediate field of runtime-selectable width (1..IN_W bits) and produces an OUT_W-bit value.
- Modes: sign-extend, zero-extend, or sign-extend then shift left.
- Two-stage pipeline with valid/ready handshake on both sides. Sits between instruction decode and the datapath immediate mux.

Parameters:
- IN_W, 8, maximum input field width in bits (≥2, ≤ OUT_W).
- OUT_W, 16, output width in bits.
- SH_W, 2, width of shift-amount port; shift range 0..2^SH_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  IN_W  raw field; bits at and above the effective width are ignored.
- in_wsel  input  $clog2(IN_W)  effective field width minus one (W_eff = in_wsel+1).
- in_mode  input  2  00 sign-extend, 01 zero-extend, 10 sign-extend+shift, 11 reserved.
- in_shamt  input  SH_W  left-shift amount; used in mode 10 only.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  OUT_W  extended result.
- out_ovf  output  1  mode 10 result not representable in OUT_W signed.
- out_err  output  1  reserved mode, or W_eff > IN_W.

Behaviour:
Reset (asynchronous, reset=1):
- Both stage valids cleared.
- out_valid=0, out_data=0, out_ovf=0, out_err=0.
- in_ready=0 while reset is high.
- Reset mid-transaction discards all in-flight data. No output appears for it.

Stage 1 (S1), on accept (in_valid & in_ready):
- Masks in_data to W_eff bits.
- Extends to OUT_W+2^SH_W-1 bits: sign fill from bit W_eff-1 for modes 00/10, zero fill for mode 01.
- Registers the extended value, mode and shamt.
- Mode 11 or W_eff > IN_W: registers value 0 with err=1.

Stage 2 (S2):
- Mode 10: shifts the extended value left by shamt.
- out_data = low OUT_W bits.
- out_ovf=1 if bits [wide-1:OUT_W-1] of the shifted value are not all equal.
- Other modes: out_data = low OUT_W bits, ovf=0.
- S2 registers drive out_data/out_ovf/out_err directly. No combinational path from in_* to out_*.

Handshake:
- S2 loads when S2 is empty or out_ready=1.
- S1 advances into S2 under the same condition.
- in_ready = !reset & (!S1_valid | !S2_valid | out_ready).
- Latency: accept at edge N gives out_valid high after edge N+1, i.e. 2 cycles from in_valid sampled to result visible.
- Throughput: 1 per cycle while out_ready=1.
- Backpressure: out_valid=1 & out_ready=0 holds out_data/out_ovf/out_err stable. S1 may still fill once; in_ready then drops.
- Bubble: an S2 transfer with S1 empty clears out_valid unless a new result arrives the same cycle.

Boundary cases:
- Simultaneous output consume and input accept with both stages full: both stages advance, no loss, no duplication.
- W_eff=1: mode 00 gives all-ones for bit=1; mode 01 gives 1.
- W_eff=IN_W=OUT_W: value passes through unchanged.
- out_valid never rises without a prior accepted input.
- in_* values are irrelevant when in_valid=0.

Test Plan:
- Reset/latency: reset high then low; in_data=8'h2D, wsel=7, mode 00, out_ready=1 → out_valid after 2 cycles, out_data=16'h002D, ovf=0, err=0.
- Width select/modes: in_data=8'hED, wsel=3 (field 4'hD), mode 00 → 16'hFFFD; same with mode 01 → 16'h000D; in_data=8'h80, wsel=7, mode 00 → 16'hFF80.
- Shift/overflow: in_data=8'h7F, wsel=7, mode 10, shamt=3 → 16'h03F8, ovf=0. Use OUT_W=8 instance with in_data=8'h40, shamt=1 → 8'h80, ovf=1.
- Backpressure: 4 back-to-back inputs (1,2,3,4), out_ready held 0 for 5 cycles → in_ready drops after 2 accepts, out_data holds 1. Release → outputs 1,2,3,4 in order, none lost or duplicated.
- Error/mid-op reset: mode 11 → out_data=0, out_err=1. Assert reset asynchronously between clock edges with both stages full → out_valid=0 immediately; no stale output after release.
- Random streaming: 1000 random inputs with random in_valid/out_ready checked against a reference model; sequence and values match exactly.

Source files
------------

// File: rtl/extend_pipe.sv
// Two-stage immediate extender: runtime field width, sign/zero extend
// or sign-extend-and-shift, with valid/ready on both sides.
module extend_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int SH_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  input  logic [$clog2(IN_W)-1:0]  in_wsel,
  input  logic [1:0]               in_mode,
  input  logic [SH_W-1:0]          in_shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_ovf,
  output logic                     out_err
);

  localparam int WD = OUT_W + (1 << SH_W) - 1;

  typedef enum logic [1:0] {
    M_SEXT = 2'b00,
    M_ZEXT = 2'b01,
    M_SHL  = 2'b10,
    M_RSV  = 2'b11
  } mode_e;

  typedef struct packed {
    logic [WD-1:0]   val;
    logic            shl;
    logic [SH_W-1:0] shamt;
    logic            err;
  } s1_t;

  s1_t           s1_d;
  s1_t           s1_q;
  logic          s1_v;
  logic          s2_v;
  logic          s2_load;
  logic          accept;
  logic          sign;
  logic          fill;
  logic          bad;
  logic          shl;
  logic [WD-1:0] shifted;
  logic          ovf_d;

  assign s2_load   = !s2_v || out_ready;
  assign in_ready  = !reset && (!s1_v || s2_load);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_v;

  always_comb begin
    sign = 1'b0;
    fill = 1'b0;
    shl  = 1'b0;
    bad  = 1'b0;
    s1_d = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (i == int'(in_wsel)) sign = in_data[i];
    end
    unique case (mode_e'(in_mode))
      M_SEXT: fill = sign;
      M_ZEXT: fill = 1'b0;
      M_SHL: begin
        fill = sign;
        shl  = 1'b1;
      end
      M_RSV: bad = 1'b1;
    endcase
    if (int'(in_wsel) >= IN_W) bad = 1'b1;
    s1_d.val = {WD{fill}};
    for (int i = 0; i < IN_W; i++) begin
      if (i <= int'(in_wsel)) s1_d.val[i] = in_data[i];
    end
    s1_d.shl   = shl;
    s1_d.shamt = in_shamt;
    if (bad) begin
      s1_d     = '0;
      s1_d.err = 1'b1;
    end
  end

  // overflow: anything above the OUT_W sign bit disagrees with it
  always_comb begin
    shifted = s1_q.val;
    if (s1_q.shl) shifted = s1_q.val << s1_q.shamt;
    ovf_d = s1_q.shl &&
            !((&shifted[WD-1:OUT_W-1]) ||
              !(|shifted[WD-1:OUT_W-1]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v     <= 1'b0;
      s1_q     <= '0;
      s2_v     <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      if (accept) begin
        s1_v <= 1'b1;
        s1_q <= s1_d;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
      if (s2_load) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_data <= shifted[OUT_W-1:0];
          out_ovf  <= ovf_d;
          out_err  <= s1_q.err;
        end
      end
    end
  end

endmodule

// File: tb/tb_extend_pipe.sv
// Scoreboard bench for extend_pipe: directed cases, backpressure,
// mid-flight reset and a randomised stream.
module tb_extend_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [2:0]  in_wsel = '0;
  logic [1:0]  in_mode = '0;
  logic [1:0]  in_shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_err;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [7:0]  s_in_data = '0;
  logic [2:0]  s_in_wsel = '0;
  logic [1:0]  s_in_mode = '0;
  logic [1:0]  s_in_shamt = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic [7:0]  s_out_data;
  logic        s_out_ovf;
  logic        s_out_err;

  typedef struct packed {
    logic [15:0] d;
    logic        o;
    logic        e;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  int   vectors = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  extend_pipe #(.IN_W(8), .OUT_W(16), .SH_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_wsel(in_wsel),
    .in_mode(in_mode), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf),
    .out_err(out_err)
  );

  extend_pipe #(.IN_W(8), .OUT_W(8), .SH_W(2)) dut_s (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_wsel(s_in_wsel),
    .in_mode(s_in_mode), .in_shamt(s_in_shamt),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_ovf(s_out_ovf),
    .out_err(s_out_err)
  );

  // arithmetic reference: exact value, then range check
  function automatic res_t model(input logic [7:0] d,
                                 input logic [2:0] ws,
                                 input logic [1:0] m,
                                 input logic [1:0] sh);
    longint v;
    int     w;
    res_t   r;
    r = '0;
    w = int'(ws) + 1;
    if (m == 2'b11) begin
      r.e = 1'b1;
      return r;
    end
    v = longint'(d) & ((longint'(1) << w) - 1);
    if (m != 2'b01 && ((v >> (w - 1)) & 1) == 1)
      v = v - (longint'(1) << w);
    if (m == 2'b10) v = v * (longint'(1) << sh);
    r.d = v[15:0];
    r.o = (m == 2'b10) && (v < -32768 || v > 32767);
    return r;
  endfunction

  // sample 1 time unit before each rising edge
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        if (in_valid && in_ready)
          exp_q.push_back(model(in_data, in_wsel,
                                in_mode, in_shamt));
        if (out_valid && out_ready)
          got_q.push_back({out_data, out_ovf, out_err});
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] ws,
                      input logic [1:0] m, input logic [1:0] sh);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_wsel  = ws;
    in_mode  = m;
    in_shamt = sh;
    #4;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (n >= 50) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout in_ready=%0b want 1", in_ready);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #4;
      n++;
    end while ((out_valid || exp_q.size() != got_q.size()) && n < 40);
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({out_valid, out_data, out_ovf, out_err, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%0b d=%h o=%0b e=%0b rdy=%0b want all 0",
               out_valid, out_data, out_ovf, out_err, in_ready);
    end
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%0b v=%0b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_latency();
    res_t e;
    res_t g;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h2D;
    in_wsel   = 3'd7;
    in_mode   = 2'b00;
    in_shamt  = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got v=%0b want 0", out_valid);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({out_valid, out_data, out_ovf, out_err} !== {1'b1, 16'h002D, 2'b00}) begin
      errors++;
      $display("FAIL latency_result got v=%0b d=%h o=%0b e=%0b want 1 002d 0 0",
               out_valid, out_data, out_ovf, out_err);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_bubble got v=%0b want 0", out_valid);
    end
    drain();
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL latency_sb got %h want %h", g, e);
      end
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL latency_count got %0d want %0d left",
               got_q.size(), exp_q.size());
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_modes();
    logic [7:0]  dv[8];
    logic [2:0]  wv[8];
    logic [1:0]  mv[8];
    logic [1:0]  sv[8];
    logic [15:0] xv[8];
    res_t        e;
    res_t        g;
    dv = '{8'hED, 8'hED, 8'h80, 8'h7F, 8'h01, 8'h01, 8'hFE, 8'hFF};
    wv = '{3'd3, 3'd3, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd7};
    mv = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1};
    sv = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    xv = '{16'hFFFD, 16'h000D, 16'hFF80, 16'h03F8,
           16'hFFFF, 16'h0001, 16'h0000, 16'h00FF};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(dv[i], wv[i], mv[i], sv[i]);
    drain();
    vectors++;
    if (got_q.size() != 8 || exp_q.size() != 8) begin
      errors++;
      $display("FAIL modes_count got %0d want 8 (model %0d)",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== {xv[i], 2'b00}) begin
        errors++;
        $display("FAIL mode_case%0d got %h want %h", i, g, {xv[i], 2'b00});
      end
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL mode_model%0d got %h want %h", i, g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_small_ovf();
    @(negedge clk);
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_data   = 8'h40;
    s_in_wsel   = 3'd7;
    s_in_mode   = 2'b10;
    s_in_shamt  = 2'd1;
    @(negedge clk);
    s_in_data  = 8'h3F;
    s_in_shamt = 2'd1;
    @(negedge clk);
    s_in_valid = 1'b0;
    #1;
    vectors++;
    if ({s_out_valid, s_out_data, s_out_ovf, s_out_err} !== {1'b1, 8'h80, 2'b10}) begin
      errors++;
      $display("FAIL small_ovf got v=%0b d=%h o=%0b e=%0b want 1 80 1 0",
               s_out_valid, s_out_data, s_out_ovf, s_out_err);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({s_out_valid, s_out_data, s_out_ovf, s_out_err} !== {1'b1, 8'h7E, 2'b00}) begin
      errors++;
      $display("FAIL small_noovf got v=%0b d=%h o=%0b e=%0b want 1 7e 0 0",
               s_out_valid, s_out_data, s_out_ovf, s_out_err);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] items[4];
    int         idx;
    int         c;
    res_t       e;
    res_t       g;
    items = '{8'd1, 8'd2, 8'd3, 8'd4};
    idx = 0;
    c = 0;
    while (idx < 4 && c < 60) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = 1'b1;
      in_data   = items[idx];
      in_wsel   = 3'd7;
      in_mode   = 2'b00;
      in_shamt  = 2'd0;
      #4;
      if (c >= 2 && c <= 4) begin
        vectors++;
        if ({in_ready, out_valid, out_data, out_err} !== {2'b01, 16'h0001, 1'b0}) begin
          errors++;
          $display("FAIL bp_hold%0d got rdy=%0b v=%0b d=%h e=%0b want 0 1 0001 0",
                   c, in_ready, out_valid, out_data, out_err);
        end
      end
      if (in_ready) idx++;
      c++;
    end
    drain();
    vectors++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL bp_count got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g.d !== 16'(i + 1) || g !== e) begin
        errors++;
        $display("FAIL bp_order%0d got %h want %h", i, g.d, 16'(i + 1));
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_error();
    res_t g;
    out_ready = 1'b1;
    send(8'hAA, 3'd7, 2'b11, 2'd2);
    drain();
    vectors++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL err_count got %0d want 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      vectors++;
      if (g !== {16'h0000, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL err_result got %h want %h", g, {16'h0000, 2'b01});
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_midreset();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    in_wsel   = 3'd7;
    in_mode   = 2'b00;
    @(negedge clk);
    in_data = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_full got v=%0b rdy=%0b want 1 0",
               out_valid, in_ready);
    end
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, out_data, in_ready} !== '0) begin
      errors++;
      $display("FAIL midrst_async got v=%0b d=%h rdy=%0b want 0 0000 0",
               out_valid, out_data, in_ready);
    end
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #4;
    vectors++;
    if (out_valid !== 1'b0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_stale got v=%0b outs=%0d want 0 0",
               out_valid, got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    int   c;
    int   bad;
    res_t e;
    res_t g;
    n = 0;
    c = 0;
    while (n < 1000 && c < 20000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom());
      in_wsel   = 3'($urandom_range(0, 7));
      in_mode   = 2'($urandom_range(0, 3));
      in_shamt  = 2'($urandom_range(0, 3));
      #4;
      if (in_valid && in_ready) n++;
      c++;
    end
    drain();
    vectors++;
    if (got_q.size() != 1000 || exp_q.size() != 1000) begin
      errors++;
      $display("FAIL rand_count got %0d want 1000 (model %0d)",
               got_q.size(), exp_q.size());
    end
    bad = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand_item got %h want %h", g, e);
        bad++;
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_small_ovf();
    test_backpressure();
    test_error();
    test_midreset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
